channel_err_inj: RTL and testbench
==================================

CHANNEL_ERR_INJ -- requirements
Module: channel_err_inj

Interface
REQ-001 SHALL provide parameter N, default 4: a random trigger fires when lfsr[N-1:0] is all ones; legal range 1..15.
REQ-002 SHALL provide parameter BURST_LEN, default 2: number of consecutive valid symbols corrupted per burst; legal range 1..15.
REQ-003 SHALL provide parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port valid_i, input, 1 bit: sym_i carries an encoder symbol this cycle.
REQ-007 SHALL have port sym_i, input, 2 bits: encoder output symbol.
REQ-008 SHALL have port mode_i, input, 2 bits: 00 pass, 01 random single, 10 random burst, 11 forced.
REQ-009 SHALL have port clr_i, input, 1 bit: synchronous clear of the statistics counters.
REQ-010 SHALL have port valid_o, output, 1 bit: sym_o is valid; this is the decoder enable.
REQ-011 SHALL have port sym_o, output, 2 bits: symbol after error injection.
REQ-012 SHALL have port err_o, output, 2 bits: XOR mask applied to sym_o.
REQ-013 SHALL have port bad_bit_ct_o, output, 16 bits: count of flipped bits.
REQ-014 SHALL have port sym_ct_o, output, 16 bits: count of valid symbols.

Function
REQ-015 SHALL register outputs: valid_o, sym_o and err_o SHALL appear exactly 1 cycle after the valid_i, sym_i pair, with sym_o = sym_i ^ err_o.
REQ-016 SHALL hold sym_o and err_o, and SHALL drive valid_o=0, on any cycle after valid_i=0.
REQ-017 SHALL use a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1, advanced only on cycles with valid_i=1.
REQ-018 SHALL define trigger = (lfsr[N-1:0] == all ones), evaluated on the pre-advance LFSR value.
REQ-019 SHALL, in mode 00, set err_o=2'b00 for every symbol.
REQ-020 SHALL, in mode 01, set err_o=2'b01 when trigger=1, else 2'b00.
REQ-021 SHALL, in mode 11, set err_o=2'b01 for every valid symbol, independent of the LFSR.
REQ-022 SHALL implement the mode-10 FSM:
- States: CLEAN, BURST, plus a 4-bit remaining-symbol counter.
- CLEAN, valid_i=1, trigger=1: corrupt the current symbol (err_o=2'b01); load counter with BURST_LEN-1; go to BURST if BURST_LEN>1, else stay in CLEAN.
- BURST, valid_i=1: corrupt the symbol (err_o=2'b01); decrement the counter; go to CLEAN when the counter reaches 0.
- BURST, valid_i=0: hold state and counter.
- Triggers are ignored while in BURST (no overlapping bursts).
REQ-023 SHALL return the FSM to CLEAN and clear the counter whenever mode_i != 10 on a valid cycle (aborting any burst in progress); the current symbol SHALL take the new mode's behaviour.
REQ-024 SHALL, on each valid symbol, increment sym_ct_o by 1 and bad_bit_ct_o by popcount(err_mask); both counters SHALL saturate at 16'hFFFF with no wrap-around.
REQ-025 SHALL give clr_i priority: both counters become 0, and a symbol arriving in the same cycle is not counted; the datapath, FSM and LFSR are unaffected.

Reset
REQ-026 SHALL, while rst=0, asynchronously force:
- valid_o=0, sym_o=2'b00, err_o=2'b00;
- both counters to 0;
- the FSM to CLEAN with counter 0;
- lfsr to LFSR_SEED.
REQ-027 SHALL abort a burst in progress on reset; the first valid symbol after rst rises SHALL use the LFSR_SEED value for its trigger.

Configuration
REQ-028 SHALL, with CHAN_ERR_STATS_EN defined, implement bad_bit_ct_o, sym_ct_o and clr_i as specified above.
REQ-029 SHALL, without CHAN_ERR_STATS_EN, omit the counter registers: both count outputs tie to 16'h0000, clr_i is ignored, and the datapath behaviour is unchanged.

Verification
REQ-030 SHALL cover pass-through: mode 00, sym_i=2'b10 with valid_i=1 -> next cycle valid_o=1, sym_o=2'b10, err_o=2'b00.
REQ-031 SHALL cover forced mode: mode 11, 10 valid symbols of 2'b11 -> each sym_o=2'b10; bad_bit_ct_o=10, sym_ct_o=10.
REQ-032 SHALL cover bursts: mode 10, N=1, BURST_LEN=2, 200 symbols -> each trigger is followed by exactly 2 consecutive corrupted symbols, and err_o matches a reference LFSR model seeded with 16'hACE1.
REQ-033 SHALL cover reset mid-burst: rst=0 during BURST -> outputs and counters are 0 immediately, lfsr=16'hACE1, and the first post-reset symbol matches the model.
REQ-034 SHALL cover counter saturation and clear: 70000 forced symbols -> both counters read 16'hFFFF; then clr_i=1 with valid_i=1 -> both counters read 0 the next cycle.
REQ-035 SHALL cover gapped input: valid_i toggling 1,0,1,0 in mode 10 mid-burst -> LFSR and burst counter advance only on valid cycles, and valid_o mirrors valid_i delayed by one cycle.

Source files
------------

// File: rtl/channel_err_inj.sv
// -----------------------------------------------------------------------------
// channel_err_inj
//
// Error injector placed between a 2-bit symbol encoder and its decoder. Each
// valid symbol is registered through to the output, XORed with an error mask
// chosen by mode_i:
//   00 pass          - never corrupted
//   01 random single - LSB flipped whenever the LFSR trigger fires
//   10 random burst  - a trigger starts a burst of BURST_LEN corrupted symbols
//   11 forced        - LSB of every valid symbol flipped
//
// The trigger fires when the low N bits of a 16-bit Fibonacci LFSR
// (x^16+x^14+x^13+x^11+1) are all ones. The LFSR value used is the one held
// before that cycle's advance. The LFSR only advances on valid cycles.
//
// Parameters:
//   N          1..15  trigger width (trigger probability about 2^-N)
//   BURST_LEN  1..15  corrupted symbols per burst in mode 10
//   LFSR_SEED         nonzero LFSR reset value
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   valid_i       in   sym_i carries a symbol this cycle
//   sym_i[1:0]    in   encoder symbol
//   mode_i[1:0]   in   injection mode (see above)
//   clr_i         in   synchronous clear of the statistics counters
//   valid_o       out  sym_o valid (decoder enable), one cycle after valid_i
//   sym_o[1:0]    out  symbol after injection, sym_i ^ err_o
//   err_o[1:0]    out  error mask applied to sym_o
//   bad_bit_ct_o  out  saturating count of flipped bits
//   sym_ct_o      out  saturating count of valid symbols
//
// Build option:
//   CHAN_ERR_STATS_EN  when defined, the statistics counters and clr_i are
//                      implemented; otherwise both counts read 0 and clr_i
//                      is ignored.
// -----------------------------------------------------------------------------
module channel_err_inj #(
    parameter int unsigned N         = 4,
    parameter int unsigned BURST_LEN = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [1:0]  sym_i,
    input  logic [1:0]  mode_i,
    input  logic        clr_i,
    output logic        valid_o,
    output logic [1:0]  sym_o,
    output logic [1:0]  err_o,
    output logic [15:0] bad_bit_ct_o,
    output logic [15:0] sym_ct_o
);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_SINGLE = 2'b01,
        MODE_BURST  = 2'b10,
        MODE_FORCED = 2'b11
    } mode_e;

    typedef enum logic {
        CLEAN = 1'b0,
        BURST = 1'b1
    } state_e;

    // Counter value loaded when a burst starts: the triggering symbol is
    // itself corrupted, so BURST_LEN-1 symbols remain.
    localparam logic [3:0] BURST_LOAD  = 4'(BURST_LEN - 1);
    localparam bit         BURST_MULTI = (BURST_LEN > 1);

    mode_e       mode;
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_next;
    logic        trigger;
    logic [1:0]  err_mask;

    assign mode = mode_e'(mode_i);

    // ------------------------------------------------------------------
    // LFSR: taps at 16,14,13,11 in Fibonacci form, shifting toward bit 0.
    // ------------------------------------------------------------------
    assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign trigger   = &lfsr_q[N-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (valid_i) begin
            lfsr_q <= lfsr_next;
        end
    end

    // ------------------------------------------------------------------
    // Burst FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Error mask selection and burst FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_mask = '0;

        case (mode)
            MODE_PASS: begin
                err_mask = '0;
            end
            MODE_SINGLE: begin
                err_mask = trigger ? 2'b01 : 2'b00;
            end
            MODE_FORCED: begin
                err_mask = 2'b01;
            end
            MODE_BURST: begin
                if (state_q == BURST) begin
                    // Triggers are ignored mid-burst; bursts never overlap.
                    err_mask = 2'b01;
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = '0;
                        state_d = CLEAN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (trigger) begin
                    err_mask = 2'b01;
                    cnt_d    = BURST_LOAD;
                    state_d  = BURST_MULTI ? BURST : CLEAN;
                end
            end
            default: begin
                err_mask = '0;
            end
        endcase

        // Any other mode on a valid cycle aborts a burst in progress.
        if (mode != MODE_BURST) begin
            state_d = CLEAN;
            cnt_d   = '0;
        end

        // Idle cycles leave the FSM untouched.
        if (!valid_i) begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Output register: symbol and mask hold across idle cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            sym_o   <= '0;
            err_o   <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                sym_o <= sym_i ^ err_mask;
                err_o <= err_mask;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics counters (optional)
    // ------------------------------------------------------------------
`ifdef CHAN_ERR_STATS_EN
    logic [15:0] bad_bit_ct_q;
    logic [15:0] sym_ct_q;
    logic [1:0]  flip_ct;
    logic [16:0] bad_sum;

    assign flip_ct = {1'b0, err_mask[1]} + {1'b0, err_mask[0]};
    // One extra bit catches overflow so the count can clamp at all ones.
    assign bad_sum = {1'b0, bad_bit_ct_q} + 17'(flip_ct);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bad_bit_ct_q <= '0;
            sym_ct_q     <= '0;
        end else if (clr_i) begin
            bad_bit_ct_q <= '0;
            sym_ct_q     <= '0;
        end else if (valid_i) begin
            bad_bit_ct_q <= bad_sum[16] ? '1 : bad_sum[15:0];
            if (sym_ct_q != '1) begin
                sym_ct_q <= sym_ct_q + 16'd1;
            end
        end
    end

    assign bad_bit_ct_o = bad_bit_ct_q;
    assign sym_ct_o     = sym_ct_q;
`else
    logic unused_clr;

    assign unused_clr   = clr_i;
    assign bad_bit_ct_o = '0;
    assign sym_ct_o     = '0;
`endif

endmodule

// File: tb/tb_channel_err_inj.sv
module tb_channel_err_inj;

    localparam int unsigned NA  = 1;
    localparam int unsigned BLA = 2;
    localparam int unsigned NB  = 3;
    localparam int unsigned BLB = 1;

`ifdef CHAN_ERR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             valid_i;
    logic [1:0]       sym_i;
    logic [1:0]       mode_i;
    logic             clr_i;
    logic [1:0]       v_o;
    logic [1:0][1:0]  s_o;
    logic [1:0][1:0]  e_o;
    logic [1:0][15:0] bad_o;
    logic [1:0][15:0] cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = u_a, 1 = u_b
    int unsigned m_n[2]  = '{NA, NB};
    int unsigned m_bl[2] = '{BLA, BLB};
    int unsigned m_lfsr[2];
    int unsigned m_rem[2];
    int unsigned m_sym_ct[2];
    int unsigned m_bad_ct[2];
    logic        m_valid[2];
    logic [1:0]  m_sym[2];
    logic [1:0]  m_err[2];

    channel_err_inj #(.N(NA), .BURST_LEN(BLA), .LFSR_SEED(16'hACE1)) u_a (
        .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
        .clr_i(clr_i), .valid_o(v_o[0]), .sym_o(s_o[0]), .err_o(e_o[0]),
        .bad_bit_ct_o(bad_o[0]), .sym_ct_o(cnt_o[0])
    );

    channel_err_inj #(.N(NB), .BURST_LEN(BLB), .LFSR_SEED(16'hACE1)) u_b (
        .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
        .clr_i(clr_i), .valid_o(v_o[1]), .sym_o(s_o[1]), .err_o(e_o[1]),
        .bad_bit_ct_o(bad_o[1]), .sym_ct_o(cnt_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned lfsr_adv(input int unsigned x);
        int unsigned fb;
        fb = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
        return (x >> 1) | (fb << 15);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lfsr[k]   = 32'hACE1;
            m_rem[k]    = 0;
            m_sym_ct[k] = 0;
            m_bad_ct[k] = 0;
            m_valid[k]  = 1'b0;
            m_sym[k]    = 2'b00;
            m_err[k]    = 2'b00;
        end
    endtask

    task automatic model_step(input logic v, input logic [1:0] s, input logic [1:0] m, input logic c);
        for (int k = 0; k < 2; k++) begin
            int unsigned mask;
            bit          trig;
            logic [1:0]  e;
            mask = (32'd1 << m_n[k]) - 1;
            trig = ((m_lfsr[k] & mask) == mask);
            e    = 2'b00;
            if (v) begin
                if (m == 2'b10) begin
                    if (m_rem[k] > 0) begin
                        e = 2'b01;
                        m_rem[k]--;
                    end else if (trig) begin
                        e = 2'b01;
                        m_rem[k] = m_bl[k] - 1;
                    end
                end else begin
                    m_rem[k] = 0;
                    if (m == 2'b11) e = 2'b01;
                    else if (m == 2'b01 && trig) e = 2'b01;
                end
                m_lfsr[k]  = lfsr_adv(m_lfsr[k]);
                m_valid[k] = 1'b1;
                m_sym[k]   = s ^ e;
                m_err[k]   = e;
            end else begin
                m_valid[k] = 1'b0;
            end
            if (STATS) begin
                if (c) begin
                    m_sym_ct[k] = 0;
                    m_bad_ct[k] = 0;
                end else if (v) begin
                    m_sym_ct[k] = (m_sym_ct[k] + 1 > 65535) ? 65535 : m_sym_ct[k] + 1;
                    m_bad_ct[k] = (m_bad_ct[k] + e[0] + e[1] > 65535) ? 65535
                                                                       : m_bad_ct[k] + e[0] + e[1];
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            string p;
            p = (k == 0) ? "a" : "b";
            check({p, ".valid_o"}, 16'(v_o[k]), 16'(m_valid[k]));
            check({p, ".sym_o"}, 16'(s_o[k]), 16'(m_sym[k]));
            check({p, ".err_o"}, 16'(e_o[k]), 16'(m_err[k]));
            check({p, ".sym_ct_o"}, cnt_o[k], 16'(m_sym_ct[k]));
            check({p, ".bad_bit_ct_o"}, bad_o[k], 16'(m_bad_ct[k]));
        end
    endtask

    // Drive one cycle, advance the model on the edge, check 1 time unit later.
    task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] m,
                         input logic c, input bit chk);
        valid_i = v;
        sym_i   = s;
        mode_i  = m;
        clr_i   = c;
        @(posedge clk);
        model_step(v, s, m, c);
        #1;
        if (chk) check_all();
    endtask

    initial begin
        logic [15:0] exp_fwd;
        logic [15:0] exp_sat;
        bit          in_burst;

        exp_fwd = STATS ? 16'd10 : 16'd0;
        exp_sat = STATS ? 16'hFFFF : 16'h0000;

        rst     = 1'b0;
        valid_i = 1'b0;
        sym_i   = 2'b00;
        mode_i  = 2'b00;
        clr_i   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        check("a.lfsr_reset", u_a.lfsr_q, 16'hACE1);
        rst = 1'b1;

        // Pass-through
        drive(1'b1, 2'b10, 2'b00, 1'b0, 1'b1);
        check("pass_sym", 16'(s_o[0]), 16'h0002);
        check("pass_err", 16'(e_o[0]), 16'h0000);
        drive(1'b0, 2'b01, 2'b00, 1'b0, 1'b1);

        // Forced mode, ten symbols after a clear
        drive(1'b0, 2'b00, 2'b11, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'b11, 2'b11, 1'b0, 1'b1);
            check("forced_sym", 16'(s_o[0]), 16'h0002);
        end
        check("forced_bad_ct", bad_o[0], exp_fwd);
        check("forced_sym_ct", cnt_o[0], exp_fwd);

        // Bursts: 200 consecutive valid symbols in mode 10
        for (int i = 0; i < 200; i++)
            drive(1'b1, 2'($urandom_range(0, 3)), 2'b10, 1'b0, 1'b1);

        // Gapped input in mode 10
        for (int i = 0; i < 40; i++)
            drive(1'(i % 2 == 0), 2'($urandom_range(0, 3)), 2'b10, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++)
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 2'b10, 1'b0, 1'b1);

        // Mixed random modes, idle cycles and clears
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0), 1'b1);

        // Reset during a burst
        in_burst = 1'b0;
        for (int i = 0; i < 64 && !in_burst; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 2'b10, 1'b0, 1'b1);
            in_burst = (m_rem[0] > 0);
        end
        check("burst_entry", 16'(in_burst), 16'h0001);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_all();
        check("a.lfsr_midreset", u_a.lfsr_q, 16'hACE1);
        check("b.lfsr_midreset", u_b.lfsr_q, 16'hACE1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++)
            drive(1'b1, 2'($urandom_range(0, 3)), 2'b10, 1'b0, 1'b1);

        // Counter saturation, then clear with a simultaneous symbol
        drive(1'b0, 2'b00, 2'b11, 1'b1, 1'b1);
        for (int i = 0; i < 70000; i++)
            drive(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
        check_all();
        check("sat_bad_ct", bad_o[0], exp_sat);
        check("sat_sym_ct", cnt_o[0], exp_sat);
        drive(1'b1, 2'b11, 2'b11, 1'b1, 1'b1);
        check("clr_bad_ct", bad_o[0], 16'h0000);
        check("clr_sym_ct", cnt_o[0], 16'h0000);
        check("clr_sym", 16'(s_o[0]), 16'h0002);
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
